// File: rtl/ipsxb_fft_frame_feeder.sv
// AXI4-Stream front end for the FFT core: sample FIFO, one config pulse per frame,
// fixed-length framing with tlast, and a frame-length monitor on the FFT output stream.
module ipsxb_fft_frame_feeder #(
  parameter  int DATA_WIDTH   = 16,
  parameter  int LOG2_FFT_LEN = 11,
  parameter  int CFG_WIDTH    = 8,
  parameter  int FIFO_DEPTH   = 4,
  localparam int BYTE_W       = ((DATA_WIDTH + 7) / 8) * 8
) (
  input  logic                  i_aclk,
  input  logic                  i_aresetn,
  input  logic                  i_s_tvalid,
  input  logic [DATA_WIDTH-1:0] i_s_tdata,
  output logic                  o_s_tready,
  output logic                  o_m_tvalid,
  output logic [2*BYTE_W-1:0]   o_m_tdata,
  output logic                  o_m_tlast,
  input  logic                  i_m_tready,
  output logic                  o_cfg_tvalid,
  output logic [CFG_WIDTH-1:0]  o_cfg_tdata,
  input  logic [CFG_WIDTH-1:0]  i_cfg_word,
  input  logic                  i_enable,
  input  logic                  i_r_tvalid,
  input  logic                  i_r_tlast,
  input  logic                  i_err_clr,
  output logic                  o_busy,
  output logic [15:0]           o_frame_cnt,
  output logic [1:0]            o_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CFG    = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    r_s_tready;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_m_tvalid;
  logic                    w_beat_max;
  logic                    w_last_hs;
  logic [LOG2_FFT_LEN-1:0] r_beat_cnt;
  logic [15:0]             r_frame_cnt;
  logic [CFG_WIDTH-1:0]    r_cfg_tdata;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic signed [BYTE_W-1:0] w_sext;
  logic [LOG2_FFT_LEN-1:0] r_r_cnt;
  logic [LOG2_FFT_LEN-1:0] w_r_cnt_nxt;
  logic                    w_r_max;
  logic [1:0]              w_err_new;
  logic [1:0]              r_err;

  assign w_wr        = i_s_tvalid && r_s_tready;
  assign w_rd        = w_m_tvalid && i_m_tready;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
  assign w_beat_max  = &r_beat_cnt;
  assign w_last_hs   = w_rd && w_beat_max;
  assign w_rd_data   = r_mem[r_rd_ptr];
  assign w_sext      = BYTE_W'($signed(w_rd_data));
  assign w_r_max     = &r_r_cnt;

  // FIFO storage, pointers and occupancy; ready is registered from the next occupancy
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_s_tready <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_s_tdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      r_count    <= w_count_nxt;
      r_s_tready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  // State register plus frame bookkeeping
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_frame_cnt <= 16'd0;
      r_cfg_tdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd) begin
        r_beat_cnt <= r_beat_cnt + LOG2_FFT_LEN'(1'b1);
      end
      if (w_last_hs) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      // Config word is captured on the transition into CFG
      if ((r_state != S_CFG) && (w_state_nxt == S_CFG)) begin
        r_cfg_tdata <= i_cfg_word;
      end
    end
  end

  // Next-state logic; a frame in progress always runs to its last beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = i_enable ? S_CFG : S_IDLE;
      S_CFG:    w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_last_hs) begin
          w_state_nxt = i_enable ? S_CFG : S_IDLE;
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state and occupancy only
  always_comb begin
    w_m_tvalid   = (r_state == S_STREAM) && (r_count != '0);
    o_m_tlast    = w_m_tvalid && w_beat_max;
    o_cfg_tvalid = (r_state == S_CFG);
    o_busy       = (r_state != S_IDLE);
  end

  assign o_m_tvalid  = w_m_tvalid;
  assign o_m_tdata   = {{BYTE_W{1'b0}}, w_sext};
  assign o_s_tready  = r_s_tready;
  assign o_cfg_tdata = r_cfg_tdata;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err       = r_err;

  // Output-stream monitor: early tlast resyncs, missing tlast wraps
  always_comb begin
    w_err_new   = 2'b00;
    w_r_cnt_nxt = r_r_cnt;
    if (i_r_tvalid) begin
      if (i_r_tlast && !w_r_max) begin
        w_err_new[0] = 1'b1;
        w_r_cnt_nxt  = '0;
      end else if (!i_r_tlast && w_r_max) begin
        w_err_new[1] = 1'b1;
        w_r_cnt_nxt  = '0;
      end else begin
        w_r_cnt_nxt  = r_r_cnt + LOG2_FFT_LEN'(1'b1);
      end
    end else begin
      w_r_cnt_nxt = r_r_cnt;
    end
  end

  // Sticky error flags; a fresh error overrides a same-cycle clear
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_r_cnt <= '0;
      r_err   <= 2'b00;
    end else begin
      r_r_cnt <= w_r_cnt_nxt;
      r_err   <= (i_err_clr ? 2'b00 : r_err) | w_err_new;
    end
  end

endmodule
